// File: rtl/ddr_data_rx.sv
// rtl/ddr_data_rx.sv - DAT0 DDR block receiver: start bit, MSB-first payload, dual CRC16 check, end bit.
module ddr_data_rx #(
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 1024
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Arm,
    input  logic       Abort,
    input  logic       ReadData_posEdge,
    input  logic       ReadData_negEdge,
    output logic       Busy,
    output logic [7:0] ByteData,
    output logic       ByteValid,
    output logic       Done,
    output logic       CrcErr,
    output logic       EndErr,
    output logic       Timeout
);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END} state_t;

    localparam logic [12:0] LAST_BYTE = 13'(BLOCK_BYTES - 1);
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);
    localparam logic [15:0] POLY      = 16'h1021;

    state_t      state;
    state_t      state_next;
    logic [12:0] byte_cnt;
    logic [1:0]  pair_cnt;
    logic [15:0] wait_cnt;
    logic [3:0]  crc_cnt;
    logic [5:0]  shift;
    logic [15:0] crc_pos;
    logic [15:0] crc_neg;

    logic start_bit;
    logic arm_ok;
    logic timeout_hit;
    logic data_last;
    logic crc_last;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? POLY : 16'h0000);
    endfunction

    assign start_bit   = !ReadData_posEdge && !ReadData_negEdge;
    assign arm_ok      = (state == IDLE) && Arm && !Abort;
    assign timeout_hit = (state == WAIT_START) && !start_bit && (wait_cnt == LAST_WAIT);
    assign data_last   = (state == DATA) && (pair_cnt == 2'd3) && (byte_cnt == LAST_BYTE);
    assign crc_last    = (state == CRC) && (crc_cnt == 4'd15);

    assign Busy = (state != IDLE);
    // Done coincides with the cycle that leaves END or expires the wait, and is suppressed by Abort/Reset
    assign Done = !Reset && !Abort && ((state == END) || timeout_hit);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (Arm) state_next = WAIT_START;
            WAIT_START: begin
                if (start_bit) begin
                    state_next = DATA;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DATA:       if (data_last) state_next = CRC;
            CRC:        if (crc_last) state_next = END;
            END:        state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (Abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            byte_cnt  <= '0;
            pair_cnt  <= '0;
            wait_cnt  <= '0;
            crc_cnt   <= '0;
            shift     <= '0;
            crc_pos   <= '0;
            crc_neg   <= '0;
            ByteData  <= '0;
            ByteValid <= 1'b0;
            CrcErr    <= 1'b0;
            EndErr    <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            ByteValid <= 1'b0;
            if (arm_ok) begin
                byte_cnt <= '0;
                pair_cnt <= '0;
                wait_cnt <= '0;
                crc_cnt  <= '0;
                crc_pos  <= '0;
                crc_neg  <= '0;
                CrcErr   <= 1'b0;
                EndErr   <= 1'b0;
                Timeout  <= 1'b0;
            end
            if (!Abort) begin
                case (state)
                    WAIT_START: begin
                        if (timeout_hit) begin
                            Timeout <= 1'b1;
                        end else if (!start_bit) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        shift    <= {shift[3:0], ReadData_posEdge, ReadData_negEdge};
                        pair_cnt <= pair_cnt + 2'd1;
                        crc_pos  <= crc16_step(crc_pos, ReadData_posEdge);
                        crc_neg  <= crc16_step(crc_neg, ReadData_negEdge);
                        if (pair_cnt == 2'd3) begin
                            ByteData  <= {shift, ReadData_posEdge, ReadData_negEdge};
                            ByteValid <= 1'b1;
                            byte_cnt  <= byte_cnt + 13'd1;
                        end
                    end
                    CRC: begin
                        // Received CRC bits are compared against the MSB and shifted out
                        if ((ReadData_posEdge != crc_pos[15]) || (ReadData_negEdge != crc_neg[15])) begin
                            CrcErr <= 1'b1;
                        end
                        crc_pos <= {crc_pos[14:0], 1'b0};
                        crc_neg <= {crc_neg[14:0], 1'b0};
                        crc_cnt <= crc_cnt + 4'd1;
                    end
                    END: begin
                        if (!(ReadData_posEdge && ReadData_negEdge)) begin
                            EndErr <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ddr_data_rx.sv
// tb/tb_ddr_data_rx.sv - directed checks of ddr_data_rx on a short-block and a full-block instance.
module tb_ddr_data_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arm = 1'b0;
    logic abort = 1'b0;
    logic rd_pos = 1'b1;
    logic rd_neg = 1'b1;

    logic       busy_a, bv_a, done_a, crc_err_a, end_err_a, tmo_a;
    logic [7:0] bd_a;
    logic       busy_b, bv_b, done_b, crc_err_b, end_err_b, tmo_b;
    logic [7:0] bd_b;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0] payload[$];
    logic [7:0] bytes_a[$];
    int         bv_cyc_a[$];
    logic [7:0] bytes_b[$];
    int         done_cnt_a = 0;
    int         done_cyc_a = 0;
    int         done_cnt_b = 0;
    int         done_cyc_b = 0;

    ddr_data_rx #(.BLOCK_BYTES(4), .TIMEOUT(10)) dut_a (
        .Clk(clk), .Reset(reset), .Arm(arm), .Abort(abort),
        .ReadData_posEdge(rd_pos), .ReadData_negEdge(rd_neg),
        .Busy(busy_a), .ByteData(bd_a), .ByteValid(bv_a), .Done(done_a),
        .CrcErr(crc_err_a), .EndErr(end_err_a), .Timeout(tmo_a)
    );

    ddr_data_rx #(.BLOCK_BYTES(512), .TIMEOUT(1024)) dut_b (
        .Clk(clk), .Reset(reset), .Arm(arm), .Abort(abort),
        .ReadData_posEdge(rd_pos), .ReadData_negEdge(rd_neg),
        .Busy(busy_b), .ByteData(bd_b), .ByteValid(bv_b), .Done(done_b),
        .CrcErr(crc_err_b), .EndErr(end_err_b), .Timeout(tmo_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bv_a) begin
            bytes_a.push_back(bd_a);
            bv_cyc_a.push_back(cyc);
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (bv_b) bytes_b.push_back(bd_b);
        if (done_b) begin
            done_cnt_b++;
            done_cyc_b = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        rd_pos = 1'b1;
        rd_neg = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic random_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drives start bit, payload, both CRCs and the end pair; abort_after >= 0 aborts before that byte
    task automatic send_block(input int abort_after, input int flip_neg, input logic ep, input logic en);
        logic [15:0] cp;
        logic [15:0] cn;
        cp = 16'h0000;
        cn = 16'h0000;
        rd_pos = 1'b0;
        rd_neg = 1'b0;
        start_cyc = cyc;
        tick();
        for (int i = 0; i < payload.size(); i++) begin
            if (i == abort_after) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                rd_pos = 1'b1;
                rd_neg = 1'b1;
                return;
            end
            for (int k = 0; k < 4; k++) begin
                rd_pos = payload[i][7-2*k];
                rd_neg = payload[i][6-2*k];
                cp = crc_step(cp, rd_pos);
                cn = crc_step(cn, rd_neg);
                tick();
            end
        end
        if (flip_neg >= 0) cn[flip_neg] = ~cn[flip_neg];
        for (int k = 15; k >= 0; k--) begin
            rd_pos = cp[k];
            rd_neg = cn[k];
            tick();
        end
        rd_pos = ep;
        rd_neg = en;
        tick();
        rd_pos = 1'b1;
        rd_neg = 1'b1;
    endtask

    initial begin
        int base;
        int dbase;
        int arm_cyc;
        int bad;

        // Reset values
        do_reset();
        @(negedge clk);
        check("reset_flags_a", {busy_a, bv_a, done_a, crc_err_a, end_err_a, tmo_a}, 0);
        check("reset_bytedata_a", bd_a, 8'h00);
        check("reset_busy_b", busy_b, 1'b0);

        // Known 4-byte block with correct CRCs
        payload.delete();
        payload.push_back(8'hA5);
        payload.push_back(8'h3C);
        payload.push_back(8'hFF);
        payload.push_back(8'h00);
        base = bytes_a.size();
        dbase = done_cnt_a;
        pulse_arm();
        send_block(-1, -1, 1'b1, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        check("blk_strobes", bytes_a.size() - base, 4);
        check("blk_byte0", bytes_a[base+0], 8'hA5);
        check("blk_byte1", bytes_a[base+1], 8'h3C);
        check("blk_byte2", bytes_a[base+2], 8'hFF);
        check("blk_byte3", bytes_a[base+3], 8'h00);
        check("blk_first_bv_lat", bv_cyc_a[base] - start_cyc, 5);
        check("blk_done_cnt", done_cnt_a - dbase, 1);
        check("blk_done_lat", done_cyc_a - start_cyc, 33);
        check("blk_flags", {crc_err_a, end_err_a, tmo_a}, 3'b000);
        check("blk_busy_after", busy_a, 1'b0);

        // Timeout with line idle plus a 0/1 glitch
        do_reset();
        base = bytes_a.size();
        dbase = done_cnt_a;
        arm_cyc = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (2) tick();
        rd_pos = 1'b0;
        rd_neg = 1'b1;
        tick();
        rd_pos = 1'b1;
        rd_neg = 1'b1;
        repeat (14) tick();
        @(negedge clk);
        check("tmo_flag", tmo_a, 1'b1);
        check("tmo_done_cnt", done_cnt_a - dbase, 1);
        check("tmo_done_lat", done_cyc_a - arm_cyc, 10);
        check("tmo_no_bv", bytes_a.size() - base, 0);
        check("tmo_busy", busy_a, 1'b0);

        // Accepted Arm clears the held Timeout, then a block with a bad end pair
        arm = 1'b1;
        tick();
        arm = 1'b0;
        @(negedge clk);
        check("arm_clears_tmo", tmo_a, 1'b0);
        check("arm_busy", busy_a, 1'b1);
        tick();
        payload.delete();
        payload.push_back(8'h12);
        payload.push_back(8'h34);
        payload.push_back(8'h56);
        payload.push_back(8'h78);
        dbase = done_cnt_a;
        send_block(-1, -1, 1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("enderr_done_cnt", done_cnt_a - dbase, 1);
        check("enderr_flag", end_err_a, 1'b1);
        check("enderr_crc_ok", crc_err_a, 1'b0);

        // Reset during CRC, together with Arm and Abort
        do_reset();
        dbase = done_cnt_a;
        pulse_arm();
        rd_pos = 1'b0;
        rd_neg = 1'b0;
        tick();
        rd_pos = 1'b1;
        rd_neg = 1'b1;
        repeat (16 + 3) tick();
        @(negedge clk);
        check("crc_state_busy", busy_a, 1'b1);
        reset = 1'b1;
        arm = 1'b1;
        abort = 1'b1;
        tick();
        reset = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("midreset_flags", {busy_a, bv_a, done_a, crc_err_a, end_err_a, tmo_a}, 0);
        check("midreset_bytedata", bd_a, 8'h00);
        repeat (20) tick();
        check("midreset_no_done", done_cnt_a - dbase, 0);
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("arm_abort_idle", busy_a, 1'b0);

        // Full 512-byte block with one neg-CRC bit flipped
        do_reset();
        random_payload(512);
        base = bytes_b.size();
        dbase = done_cnt_b;
        pulse_arm();
        send_block(-1, 5, 1'b1, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        check("big_strobes", bytes_b.size() - base, 512);
        bad = 0;
        for (int i = 0; i < 512; i++) if (bytes_b[base+i] !== payload[i]) bad++;
        check("big_bytes_bad", bad, 0);
        check("big_done_cnt", done_cnt_b - dbase, 1);
        check("big_done_lat", done_cyc_b - start_cyc, 4 * 512 + 17);
        check("big_crcerr", crc_err_b, 1'b1);
        check("big_enderr", end_err_b, 1'b0);

        // Abort after 100 bytes, then a clean block
        do_reset();
        random_payload(512);
        base = bytes_b.size();
        dbase = done_cnt_b;
        pulse_arm();
        send_block(100, -1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rd_pos = 1'($urandom_range(0, 1));
            rd_neg = 1'($urandom_range(0, 1));
            tick();
        end
        rd_pos = 1'b1;
        rd_neg = 1'b1;
        @(negedge clk);
        check("abort_strobes", bytes_b.size() - base, 100);
        check("abort_no_done", done_cnt_b - dbase, 0);
        check("abort_busy", busy_b, 1'b0);
        tick();
        random_payload(512);
        base = bytes_b.size();
        dbase = done_cnt_b;
        pulse_arm();
        send_block(-1, -1, 1'b1, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        check("reblk_strobes", bytes_b.size() - base, 512);
        bad = 0;
        for (int i = 0; i < 512; i++) if (bytes_b[base+i] !== payload[i]) bad++;
        check("reblk_bytes_bad", bad, 0);
        check("reblk_done_cnt", done_cnt_b - dbase, 1);
        check("reblk_flags", {crc_err_b, end_err_b, tmo_b}, 3'b000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
